// File: rtl/io_bus_pkg.sv
// Shared definitions for the I/O-page controller: FSM encoding, status word
// layout and default geometry.
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Status word bit positions
  localparam int ST_TO       = 0;
  localparam int ST_BOTH     = 1;
  localparam int ST_SLOT_LSB = 8;
  localparam int ST_CNT_LSB  = 16;

  // Default geometry
  localparam int DEF_SLOTS     = 16;
  localparam int DEF_TIMEOUT   = 255;
  localparam int DEF_STAT_SLOT = 15;

endpackage

// File: rtl/io_bus_if.sv
// CPU-side request and device-side bus of the I/O page, bundled together.
interface io_bus_if
  import io_bus_pkg::*;
#(
  parameter int SLOTS = DEF_SLOTS
);
  localparam int AW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic                  io_en;
  logic [AW-1:0]         io_adr;
  logic                  rd;
  logic                  wr;
  logic [31:0]           din;
  logic [31:0]           dout;
  logic                  io_wait;
  logic [SLOTS-1:0]      dev_sel;
  logic                  dev_rd;
  logic                  dev_wr;
  logic [31:0]           dev_wdata;
  logic [32*SLOTS-1:0]   dev_rdata;
  logic [SLOTS-1:0]      dev_ack;

  // Controller side
  modport slave (
    input  io_en, io_adr, rd, wr, din, dev_rdata, dev_ack,
    output dout, io_wait, dev_sel, dev_rd, dev_wr, dev_wdata
  );

  // CPU and device side
  modport master (
    output io_en, io_adr, rd, wr, din, dev_rdata, dev_ack,
    input  dout, io_wait, dev_sel, dev_rd, dev_wr, dev_wdata
  );

endinterface

// File: rtl/io_bus_stat.sv
// Sticky status register: timeout flag, simultaneous rd/wr flag, last
// timed-out slot and a saturating timeout counter. A clear overrides events.
module io_bus_stat
  import io_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        to_evt,
  input  logic [3:0]  to_slot,
  input  logic        both_evt,
  output logic [31:0] stat_word
);

  logic        to_q, to_d;
  logic        both_q, both_d;
  logic [3:0]  slot_q, slot_d;
  logic [15:0] cnt_q, cnt_d;

  // Next status: clear wins, otherwise accumulate sticky events
  always_comb begin
    to_d   = to_q;
    both_d = both_q;
    slot_d = slot_q;
    cnt_d  = cnt_q;
    if (clr) begin
      to_d   = 1'b0;
      both_d = 1'b0;
      slot_d = 4'd0;
      cnt_d  = 16'd0;
    end else begin
      if (to_evt) begin
        to_d   = 1'b1;
        slot_d = to_slot;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
      if (both_evt) both_d = 1'b1;
    end
  end

  // Status state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      to_q   <= 1'b0;
      both_q <= 1'b0;
      slot_q <= 4'd0;
      cnt_q  <= 16'd0;
    end else begin
      to_q   <= to_d;
      both_q <= both_d;
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

  // Assemble the CPU-visible status word
  always_comb begin
    stat_word                       = '0;
    stat_word[ST_TO]                = to_q;
    stat_word[ST_BOTH]              = both_q;
    stat_word[ST_SLOT_LSB +: 4]     = slot_q;
    stat_word[ST_CNT_LSB +: 16]     = cnt_q;
  end

endmodule

// File: rtl/io_bus.sv
// I/O-page controller: sequences each CPU access through IDLE/BUSY/DONE,
// issues single-cycle device strobes, waits for per-slot acks with a
// timeout, and serves the status register from a reserved slot.
module io_bus
  import io_bus_pkg::*;
#(
  parameter int          SLOTS     = DEF_SLOTS,
  parameter logic [15:0] FAST_MASK = 16'h00FF,
  parameter int          TIMEOUT   = DEF_TIMEOUT,
  parameter int          STAT_SLOT = DEF_STAT_SLOT
) (
  input  logic      clk,
  input  logic      rst,
  io_bus_if.slave   bus
);

  localparam int             AW     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int             CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  TO_LIM = CW'(TIMEOUT);
  localparam logic [AW-1:0]  STAT_A = AW'(STAT_SLOT);

  state_e            state_q, state_d;
  logic [AW-1:0]     slot_q, slot_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       dout_q, dout_d;
  logic [SLOTS-1:0]  sel_q, sel_d;
  logic              rd_stb_q, rd_stb_d;
  logic              wr_stb_q, wr_stb_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;

  logic              req;
  logic              wait_c;
  logic              is_stat;
  logic              acked;
  logic [31:0]       rdata_sel;
  logic              stat_clr;
  logic              stat_to;
  logic              stat_both;
  logic [3:0]        stat_slot;
  logic [31:0]       stat_word;

  assign req       = bus.io_en & (bus.rd | bus.wr);
  assign is_stat   = (slot_q == STAT_A);
  assign rdata_sel = bus.dev_rdata[{slot_q, 5'd0} +: 32];
  assign acked     = FAST_MASK[slot_q] | is_stat | bus.dev_ack[slot_q];
  assign stat_slot = 4'(slot_q);

  // Next-state and output logic for the access sequencer
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    dout_d    = dout_q;
    sel_d     = sel_q;
    rd_stb_d  = 1'b0;
    wr_stb_d  = 1'b0;
    wcnt_d    = wcnt_q;
    wait_c    = 1'b0;
    stat_clr  = 1'b0;
    stat_to   = 1'b0;
    stat_both = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          wait_c    = 1'b1;
          slot_d    = bus.io_adr;
          wr_d      = bus.wr;
          wdata_d   = bus.din;
          stat_both = bus.rd & bus.wr;
          wcnt_d    = '0;
          state_d   = ST_BUSY;
          // The status slot is served internally and never reaches a device
          if (bus.io_adr != STAT_A) begin
            sel_d    = SLOTS'(1) << bus.io_adr;
            rd_stb_d = ~bus.wr;
            wr_stb_d = bus.wr;
          end
        end
      end
      ST_BUSY: begin
        wait_c = 1'b1;
        if (acked) begin
          if (!wr_q) dout_d = is_stat ? stat_word : rdata_sel;
          if (wr_q && is_stat && wdata_q[0]) stat_clr = 1'b1;
          sel_d   = '0;
          state_d = ST_DONE;
        end else if ((TIMEOUT != 0) && ((wcnt_q + CW'(1)) == TO_LIM)) begin
          dout_d  = 32'h0;
          stat_to = 1'b1;
          sel_d   = '0;
          state_d = ST_DONE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      slot_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= 32'h0;
      dout_q   <= 32'h0;
      sel_q    <= '0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      dout_q   <= dout_d;
      sel_q    <= sel_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      wcnt_q   <= wcnt_d;
    end
  end

  io_bus_stat u_stat (
    .clk       (clk),
    .rst       (rst),
    .clr       (stat_clr),
    .to_evt    (stat_to),
    .to_slot   (stat_slot),
    .both_evt  (stat_both),
    .stat_word (stat_word)
  );

  assign bus.io_wait   = wait_c & ~rst;
  assign bus.dout      = dout_q;
  assign bus.dev_sel   = sel_q;
  assign bus.dev_rd    = rd_stb_q;
  assign bus.dev_wr    = wr_stb_q;
  assign bus.dev_wdata = wdata_q;

endmodule

// File: tb/tb_io_bus.sv
// Bench for io_bus: two controllers (A: slot 7 slow, long timeout;
// B: timeout of 4) driven by directed accesses and checked every cycle
// against an access-level model, plus literal expectations per access.
module tb_io_bus;

  logic clk;
  logic rst;

  io_bus_if #(.SLOTS(16)) bus_a ();
  io_bus_if #(.SLOTS(16)) bus_b ();

  io_bus #(.FAST_MASK(16'h007F), .TIMEOUT(255)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  io_bus #(.FAST_MASK(16'h00FF), .TIMEOUT(4))   dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Per-instance stimulus and observed outputs
  logic         en   [2];
  logic [3:0]   adr  [2];
  logic         rdq  [2];
  logic         wrq  [2];
  logic [31:0]  din  [2];
  logic [511:0] rdata[2];
  logic [15:0]  ack  [2];
  logic [31:0]  o_dout[2], o_wdata[2];
  logic         o_wait[2], o_rd[2], o_wr[2];
  logic [15:0]  o_sel[2];

  assign bus_a.io_en = en[0];  assign bus_b.io_en = en[1];
  assign bus_a.io_adr = adr[0]; assign bus_b.io_adr = adr[1];
  assign bus_a.rd = rdq[0];    assign bus_b.rd = rdq[1];
  assign bus_a.wr = wrq[0];    assign bus_b.wr = wrq[1];
  assign bus_a.din = din[0];   assign bus_b.din = din[1];
  assign bus_a.dev_rdata = rdata[0]; assign bus_b.dev_rdata = rdata[1];
  assign bus_a.dev_ack = ack[0];     assign bus_b.dev_ack = ack[1];
  assign o_dout[0] = bus_a.dout;       assign o_dout[1] = bus_b.dout;
  assign o_wdata[0] = bus_a.dev_wdata; assign o_wdata[1] = bus_b.dev_wdata;
  assign o_wait[0] = bus_a.io_wait;    assign o_wait[1] = bus_b.io_wait;
  assign o_rd[0] = bus_a.dev_rd;       assign o_rd[1] = bus_b.dev_rd;
  assign o_wr[0] = bus_a.dev_wr;       assign o_wr[1] = bus_b.dev_wr;
  assign o_sel[0] = bus_a.dev_sel;     assign o_sel[1] = bus_b.dev_sel;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- access-level reference model ----------------
  // ph: 0 = no access, 1 = access in progress, 2 = access just finished
  int          ph[2];
  int          nb[2];       // device-wait cycles already spent in this access
  logic [3:0]  m_slot[2];
  logic        m_wr[2];
  logic [31:0] m_dout[2], m_wdata[2];
  logic [15:0] s_cnt[2];
  logic [3:0]  s_slot[2];
  logic        s_both[2], s_to[2];
  bit          started = 0;

  function automatic int tmo_of(input int k);
    return (k == 0) ? 255 : 4;
  endfunction

  function automatic bit fast_of(input int k, input logic [3:0] s);
    logic [15:0] m;
    m = (k == 0) ? 16'h007F : 16'h00FF;
    return m[s];
  endfunction

  function automatic logic [31:0] stat_of(input int k);
    return {s_cnt[k], 4'h0, s_slot[k], 6'h0, s_both[k], s_to[k]};
  endfunction

  always @(posedge clk) begin
    started <= 1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k] <= 0; nb[k] <= 0; m_slot[k] <= 0; m_wr[k] <= 0;
        m_dout[k] <= 0; m_wdata[k] <= 0;
        s_cnt[k] <= 0; s_slot[k] <= 0; s_both[k] <= 0; s_to[k] <= 0;
      end else if (ph[k] == 0) begin
        if (en[k] && (rdq[k] || wrq[k])) begin
          ph[k] <= 1; nb[k] <= 0; m_slot[k] <= adr[k]; m_wr[k] <= wrq[k];
          m_wdata[k] <= din[k];
          if (rdq[k] && wrq[k]) s_both[k] <= 1'b1;
        end
      end else if (ph[k] == 1) begin
        if (fast_of(k, m_slot[k]) || m_slot[k] == 4'd15 || ack[k][m_slot[k]]) begin
          if (!m_wr[k])
            m_dout[k] <= (m_slot[k] == 4'd15) ? stat_of(k) : rdata[k][32*m_slot[k] +: 32];
          if (m_wr[k] && m_slot[k] == 4'd15 && m_wdata[k][0]) begin
            s_cnt[k] <= 0; s_slot[k] <= 0; s_both[k] <= 0; s_to[k] <= 0;
          end
          ph[k] <= 2;
        end else if (nb[k] + 1 == tmo_of(k)) begin
          m_dout[k] <= 32'h0; s_to[k] <= 1'b1; s_slot[k] <= m_slot[k];
          if (s_cnt[k] != 16'hFFFF) s_cnt[k] <= s_cnt[k] + 16'd1;
          ph[k] <= 2;
        end else begin
          nb[k] <= nb[k] + 1;
        end
      end else begin
        ph[k] <= 0;
      end
    end
  end

  // Per-cycle comparison of both controllers against the model
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        logic        e_wait, e_rd, e_wr;
        logic [15:0] e_sel;
        bool_calc: begin
          e_wait = !rst && ((ph[k] == 0 && en[k] && (rdq[k] || wrq[k])) || ph[k] == 1);
          e_sel  = (ph[k] == 1 && m_slot[k] != 4'd15) ? (16'h1 << m_slot[k]) : 16'h0;
          e_rd   = (ph[k] == 1 && nb[k] == 0 && !m_wr[k] && m_slot[k] != 4'd15);
          e_wr   = (ph[k] == 1 && nb[k] == 0 &&  m_wr[k] && m_slot[k] != 4'd15);
        end
        chk($sformatf("io_wait[%0d]", k), {31'h0, o_wait[k]}, {31'h0, e_wait});
        chk($sformatf("dev_sel[%0d]", k), {16'h0, o_sel[k]}, {16'h0, e_sel});
        chk($sformatf("dev_rd[%0d]", k), {31'h0, o_rd[k]}, {31'h0, e_rd});
        chk($sformatf("dev_wr[%0d]", k), {31'h0, o_wr[k]}, {31'h0, e_wr});
        chk($sformatf("dout[%0d]", k), o_dout[k], m_dout[k]);
        chk($sformatf("dev_wdata[%0d]", k), o_wdata[k], m_wdata[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  // One CPU access: request held through the finishing cycle. ack_at = BUSY
  // cycle (1-based) on which the device acks; 0 = never. Slot 14 acks
  // continuously as unselected noise.
  task automatic access(input int k, input logic [3:0] a, input logic r, input logic w,
                        input logic [31:0] d, input int ack_at,
                        output int nwait, output int nrd, output int nwr);
    bit fin;
    nwait = 0; nrd = 0; nwr = 0; fin = 0;
    en[k] = 1'b1; adr[k] = a; rdq[k] = r; wrq[k] = w; din[k] = d;
    for (int c = 0; c < 300 && !fin; c++) begin
      ack[k] = ((ack_at > 0 && c == ack_at) ? (16'h1 << a) : 16'h0) |
               (16'h4000 & ~(16'h1 << a));
      @(negedge clk);
      if (o_wait[k]) nwait++; else fin = 1;
      if (o_rd[k]) nrd++;
      if (o_wr[k]) nwr++;
      @(posedge clk); #1;
    end
    chk("access_completes", {31'h0, fin}, 32'h1);
    en[k] = 1'b0; rdq[k] = 1'b0; wrq[k] = 1'b0; ack[k] = 16'h0;
  endtask

  int nw, nr, nx;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      en[k] = 0; adr[k] = 0; rdq[k] = 0; wrq[k] = 0; din[k] = 0; ack[k] = 0;
      for (int s = 0; s < 16; s++) rdata[k][32*s +: 32] = 32'hD000_0000 | s;
    end
    rdata[0][0 +: 32]      = 32'h0000_1234;
    rdata[0][32*7 +: 32]   = 32'h0000_001C;
    rdata[1][32*10 +: 32]  = 32'h0000_A5A5;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_dout", o_dout[0], 32'h0);
    chk("reset_sel", {16'h0, o_sel[1]}, 32'h0);
    chk("reset_wait", {31'h0, o_wait[0]}, 32'h0);
    @(posedge clk); #1;

    // Controller A: fast read, slow read, write, back-to-back read
    access(0, 4'd0, 1, 0, 32'h0, 0, nw, nr, nx);
    chk("fast_rd_wait", nw, 2); chk("fast_rd_pulse", nr, 1);
    chk("fast_rd_dout", o_dout[0], 32'h0000_1234);
    access(0, 4'd7, 1, 0, 32'h0, 6, nw, nr, nx);
    chk("slow_rd_wait", nw, 7); chk("slow_rd_pulse", nr, 1);
    chk("slow_rd_dout", o_dout[0], 32'h0000_001C);
    access(0, 4'd3, 0, 1, 32'h0000_CAFE, 0, nw, nr, nx);
    chk("wr_pulse", nx, 1); chk("wr_no_rd", nr, 0);
    chk("wr_keeps_dout", o_dout[0], 32'h0000_001C);
    chk("wr_wdata", o_wdata[0], 32'h0000_CAFE);
    access(0, 4'd5, 1, 0, 32'h0, 0, nw, nr, nx);
    chk("b2b_rd_dout", o_dout[0], 32'hD000_0005);

    // Controller B: timeout, status, clear, ack-on-timeout, rd&wr
    access(1, 4'd9, 1, 0, 32'h0, 0, nw, nr, nx);
    chk("to_wait", nw, 5); chk("to_dout", o_dout[1], 32'h0);
    access(1, 4'd15, 1, 0, 32'h0, 0, nw, nr, nx);
    chk("stat_after_to", o_dout[1], 32'h0001_0901);
    chk("stat_not_forwarded", nr, 0);
    access(1, 4'd15, 0, 1, 32'h0000_0001, 0, nw, nr, nx);
    access(1, 4'd15, 1, 0, 32'h0, 0, nw, nr, nx);
    chk("stat_cleared", o_dout[1], 32'h0);
    access(1, 4'd10, 1, 0, 32'h0, 4, nw, nr, nx);
    chk("ack_on_to_dout", o_dout[1], 32'h0000_A5A5); chk("ack_on_to_wait", nw, 5);
    access(1, 4'd15, 1, 0, 32'h0, 0, nw, nr, nx);
    chk("ack_on_to_stat", o_dout[1], 32'h0);
    access(1, 4'd2, 1, 1, 32'h0000_0077, 0, nw, nr, nx);
    chk("both_wr_pulse", nx, 1); chk("both_no_rd", nr, 0);
    access(1, 4'd15, 1, 0, 32'h0, 0, nw, nr, nx);
    chk("stat_both", o_dout[1], 32'h0000_0002);

    // Reset in the middle of a slow access on B
    en[1] = 1; adr[1] = 4'd9; rdq[1] = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; en[1] = 0; rdq[1] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_sel", {16'h0, o_sel[1]}, 32'h0);
    chk("mid_rst_wait", {31'h0, o_wait[1]}, 32'h0);
    chk("mid_rst_dout", o_dout[1], 32'h0);
    nr = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_rd[1] || o_wr[1]) nr++;
    end
    chk("mid_rst_no_strobe", nr, 0);
    @(posedge clk); #1;
    access(1, 4'd1, 1, 0, 32'h0, 0, nw, nr, nx);
    chk("post_rst_rd_dout", o_dout[1], 32'hD000_0001); chk("post_rst_rd_wait", nw, 2);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus.md
Name: io_bus

Overview:
- Parametrised I/O-page controller. It sits between the CPU and the memory-mapped peripherals: timer, board I/O, serial, SPI, mouse, keyboard, and future devices.
- It generalises the plain I/O address decode and read mux into a sequenced access with:
  - per-slot wait/acknowledge;
  - single-cycle read/write strobes, so a read with side effects (e.g. keyboard pop) is never repeated during a CPU stall;
  - a timeout with a sticky error/status register in a reserved slot.
- It drives a stall output that the top level ORs into the CPU wait input.

Parameters:
- SLOTS, 16, number of device slots; io_adr width is clog2(SLOTS); power of two, max 16.
- FAST_MASK, 16'h00FF, bit i = 1: slot i is zero-wait and its ack is implied; bit i = 0: the access waits for dev_ack[i].
- TIMEOUT, 255, BUSY cycles before an unacknowledged access aborts; 0 disables the timeout.
- STAT_SLOT, 15, slot decoded internally as the status register; never forwarded to a device.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- io_en  in  1  CPU access targets the I/O page (decoded upstream)
- io_adr  in  clog2(SLOTS)  word slot within the I/O page
- rd  in  1  CPU read request (level)
- wr  in  1  CPU write request (level)
- din  in  32  CPU write data
- dout  out  32  read data to the CPU, registered
- io_wait  out  1  stall request to the CPU
- dev_sel  out  SLOTS  one-hot device select, held for the whole access
- dev_rd  out  1  one-cycle read strobe
- dev_wr  out  1  one-cycle write strobe
- dev_wdata  out  32  latched write data
- dev_rdata  in  32*SLOTS  device read data; slot i at bits [32i+31:32i]
- dev_ack  in  SLOTS  device completion; sampled only for the selected slot

Behaviour:
- Reset (synchronous): state IDLE, dout=0, dev_sel=0, dev_rd=dev_wr=0, dev_wdata=0, status=0. While rst=1, io_wait=0. Reset mid-access aborts the access without a strobe or status update.
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - A request is io_en & (rd | wr).
  - On a request, io_wait=1 combinationally in the same cycle.
  - Latch slot, direction and din; go to BUSY.
  - rd & wr together counts as a write and sets status.BOTH.
- BUSY, first cycle:
  - dev_sel[slot]=1.
  - Exactly one of dev_rd/dev_wr is 1 for this single cycle.
  - Wait counter is cleared to 0. io_wait=1.
- BUSY, each cycle:
  - The access is acked when the slot is FAST_MASK, or is STAT_SLOT, or dev_ack[slot]=1.
  - On ack: a read registers dev_rdata[slot] (or the status word) into dout; go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT (TIMEOUT≠0): dout=32'h0, set status.TO, record the slot, increment the saturating timeout count, go to DONE.
  - An ack in the same cycle as the timeout wins; no error is recorded.
- DONE:
  - io_wait=0, dev_sel=0; dout holds its value.
  - The CPU completes on this edge. Request inputs are ignored in DONE; next state is IDLE.
  - A back-to-back request is accepted in the following IDLE cycle.
- Latency: a fast or status slot stalls 2 cycles (request cycle + BUSY). An acked slot stalls 2+n cycles, where n is the number of BUSY cycles before the ack.
- dout keeps its last read value after writes.
- dev_ack on unselected slots, and dev_ack outside BUSY, is ignored.
- Status word (read at STAT_SLOT): [31:16] timeout count (saturates at 16'hFFFF), [11:8] last timed-out slot, [1] BOTH, [0] TO.
- A write to STAT_SLOT with din[0]=1 clears the whole status word; with din[0]=0 it has no effect.
- When a clear and a timeout fall in the same cycle, the clear wins. The two cannot coincide, because accesses are serial.

Decomposition:
- io_bus_pkg (shared header) holds:
  - the FSM state encodings;
  - status bit positions (ST_TO=0, ST_BOTH=1, ST_SLOT_LSB=8, ST_CNT_LSB=16);
  - default constants for SLOTS/TIMEOUT/STAT_SLOT.
- Sub-module io_bus_stat holds the sticky status register, the saturating counter and the clear logic.
- The FSM, strobe generation and read mux stay in io_bus.

Test Plan:
- Fast slot read: io_en=1, rd=1, io_adr=0, dev_rdata[0]=32'h1234 → io_wait high 2 cycles; dev_rd pulses exactly once; dout=32'h1234 in DONE.
- Keyboard-style slow read, slot 7 with FAST_MASK bit cleared: dev_ack after 5 BUSY cycles with rdata 32'h1C → dev_rd is a single pulse; io_wait high 7 cycles; dout=32'h1C.
- Timeout, TIMEOUT=4: read a non-fast slot 9 that never acks → DONE after 4 BUSY cycles; dout=0; status read returns 32'h0001_0901.
- Ack on the timeout cycle: dev_ack asserted on BUSY cycle 4 with TIMEOUT=4 → data returned; status.TO stays 0.
- Status clear: write STAT_SLOT with din=1 after a timeout → next status read returns 0. Also: rd=wr=1 to slot 2 → dev_wr pulse only; status bit 1 set.
- Reset mid-access: assert rst during BUSY → next cycle dev_sel=0, io_wait=0, dout=0; no strobe on the following cycles; a new request is accepted normally afterwards.
